// File: rtl/debug_controller_pkg.sv
// debug_controller_pkg
//   Shared definitions for the debug controller: default command opcodes,
//   default dump length and the controller state encoding.
//   No ports (package).
package debug_controller_pkg;

   localparam int unsigned DUMP_WORDS_DEF = 32;

   localparam logic [7:0] CMD_RUN_DEF  = 8'h01;
   localparam logic [7:0] CMD_STEP_DEF = 8'h02;
   localparam logic [7:0] CMD_HALT_DEF = 8'h03;
   localparam logic [7:0] CMD_DUMP_DEF = 8'h04;

   typedef enum logic [2:0] {
      ST_HALTED   = 3'd0,
      ST_RUN      = 3'd1,
      ST_STEP     = 3'd2,
      ST_DUMP_HDR = 3'd3,
      ST_DUMP_RD  = 3'd4,
      ST_DUMP_TX  = 3'd5
   } dbg_state_e;

endpackage

// File: rtl/debug_controller_if.sv
// debug_controller_if
//   Command and transmit byte channels of the debug controller.
//   Handshake: on both channels a byte moves on a rising clock edge where
//   valid and ready are both 1. While valid=1 and ready=0 the source keeps
//   its data stable; ready may depend combinationally on valid.
//   Signals:
//     cmd_valid/cmd_data (host -> controller), cmd_ready (controller -> host)
//     tx_valid/tx_data (controller -> host), tx_ready (host -> controller)
//   Modports: slave = controller side, master = host side.
interface debug_controller_if;

   logic       cmd_valid;
   logic [7:0] cmd_data;
   logic       cmd_ready;
   logic       tx_valid;
   logic [7:0] tx_data;
   logic       tx_ready;

   modport slave (
      input  cmd_valid,
      input  cmd_data,
      output cmd_ready,
      output tx_valid,
      output tx_data,
      input  tx_ready
   );

   modport master (
      output cmd_valid,
      output cmd_data,
      input  cmd_ready,
      input  tx_valid,
      input  tx_data,
      output tx_ready
   );

endinterface

// File: rtl/debug_controller_word_serializer.sv
// word_serializer
//   Sends a 32-bit word as 4 bytes, MSB first, over a valid/ready channel.
//   A new word may be loaded while the last byte of the previous word is
//   being accepted, so back-to-back words leave no idle cycle.
//   Ports:
//     clk, rst        clock, asynchronous active-high reset
//     load_i, word_i  load a new word (only when ready_o=1)
//     ready_o         serializer can take a word this cycle
//     tx_valid_o, tx_data_o, tx_ready_i  outgoing byte channel
module word_serializer (
   input  logic        clk,
   input  logic        rst,
   input  logic        load_i,
   input  logic [31:0] word_i,
   output logic        ready_o,
   output logic        tx_valid_o,
   output logic [7:0]  tx_data_o,
   input  logic        tx_ready_i
);

   logic [31:0] shift_q, shift_d;
   logic [2:0]  left_q, left_d;   // bytes still to send

   // After the fourth shift the register is all zeros, so tx_data_o idles at 0.
   assign tx_valid_o = (left_q != 3'd0);
   assign tx_data_o  = shift_q[31:24];
   assign ready_o    = (left_q == 3'd0) || ((left_q == 3'd1) && tx_ready_i);

   always_comb begin
      shift_d = shift_q;
      left_d  = left_q;
      if (load_i) begin
         shift_d = word_i;
         left_d  = 3'd4;
      end else if (tx_valid_o && tx_ready_i) begin
         shift_d = {shift_q[23:0], 8'h00};
         left_d  = left_q - 3'd1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         shift_q <= '0;
         left_q  <= '0;
      end else begin
         shift_q <= shift_d;
         left_q  <= left_d;
      end
   end

endmodule

// File: rtl/debug_controller.sv
// debug_controller
//   Run/step/halt control of a pipeline plus a state dump over a byte stream.
//   A dump sends the PC, the enabled-cycle counter and DUMP_WORDS data-memory
//   words, each as 4 bytes MSB first.
//   Ports:
//     clk, reset     clock, asynchronous active-high reset
//     bus            command and transmit channels (slave side)
//     pipe_en        pipeline clock enable
//     halt_in        pipeline fetched the halt instruction
//     pc_value       current fetch PC
//     debugMode      data memory in debug-read mode
//     DebugAddress   debug memory word address
//     mem_rdata      memory word for DebugAddress, one cycle later
//     state_o        current controller state
module debug_controller
   import debug_controller_pkg::*;
#(
   parameter int unsigned DUMP_WORDS = DUMP_WORDS_DEF,
   parameter logic [7:0]  CMD_RUN    = CMD_RUN_DEF,
   parameter logic [7:0]  CMD_STEP   = CMD_STEP_DEF,
   parameter logic [7:0]  CMD_HALT   = CMD_HALT_DEF,
   parameter logic [7:0]  CMD_DUMP   = CMD_DUMP_DEF
) (
   input  logic                clk,
   input  logic                reset,
   debug_controller_if.slave   bus,
   output logic                pipe_en,
   input  logic                halt_in,
   input  logic [31:0]         pc_value,
   output logic                debugMode,
   output logic [31:0]         DebugAddress,
   input  logic [31:0]         mem_rdata,
   output dbg_state_e          state_o
);

   dbg_state_e  state_q, state_d;
   logic [31:0] cycle_cnt_q, cycle_cnt_d;
   logic [31:0] pc_cap_q, pc_cap_d;
   logic [31:0] addr_q, addr_d;
   logic        hdr_sel_q, hdr_sel_d;   // 0: PC word next, 1: counter word next
   logic        done_q, done_d;         // last memory word handed to serializer

   logic        cmd_ready;
   logic        cmd_acc;
   logic        ser_load;
   logic [31:0] ser_word;
   logic        ser_ready;

   assign bus.cmd_ready = cmd_ready;
   assign cmd_acc       = bus.cmd_valid && cmd_ready;
   assign DebugAddress  = addr_q;
   assign state_o       = state_q;

   // State register
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= ST_HALTED;
         cycle_cnt_q <= '0;
         pc_cap_q    <= '0;
         addr_q      <= '0;
         hdr_sel_q   <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         cycle_cnt_q <= cycle_cnt_d;
         pc_cap_q    <= pc_cap_d;
         addr_q      <= addr_d;
         hdr_sel_q   <= hdr_sel_d;
         done_q      <= done_d;
      end
   end

   // Next state
   always_comb begin
      state_d     = state_q;
      cycle_cnt_d = cycle_cnt_q + {31'd0, pipe_en};
      pc_cap_d    = pc_cap_q;
      addr_d      = addr_q;
      hdr_sel_d   = hdr_sel_q;
      done_d      = done_q;
      unique case (state_q)
         ST_HALTED: begin
            if (cmd_acc) begin
               if (bus.cmd_data == CMD_RUN) begin
                  state_d = ST_RUN;
               end else if (bus.cmd_data == CMD_STEP) begin
                  state_d = ST_STEP;
               end else if (bus.cmd_data == CMD_DUMP) begin
                  state_d   = ST_DUMP_HDR;
                  pc_cap_d  = pc_value;
                  hdr_sel_d = 1'b0;
               end
            end
         end
         ST_RUN: begin
            if (halt_in || (cmd_acc && (bus.cmd_data == CMD_HALT))) begin
               state_d = ST_HALTED;
            end
         end
         ST_STEP: state_d = ST_HALTED;
         ST_DUMP_HDR: begin
            if (ser_load) begin
               hdr_sel_d = 1'b1;
               if (hdr_sel_q) begin
                  state_d = ST_DUMP_RD;
               end
            end
         end
         // One cycle for the memory to answer the address presented.
         ST_DUMP_RD: state_d = ST_DUMP_TX;
         ST_DUMP_TX: begin
            if (done_q) begin
               // ser_ready here means the final byte is being accepted.
               if (ser_ready) begin
                  state_d = ST_HALTED;
                  addr_d  = '0;
                  done_d  = 1'b0;
               end
            end else if (ser_load) begin
               if (addr_q == 32'(DUMP_WORDS - 1)) begin
                  done_d = 1'b1;
               end else begin
                  addr_d  = addr_q + 32'd1;
                  state_d = ST_DUMP_RD;
               end
            end
         end
         default: state_d = ST_HALTED;
      endcase
   end

   // Outputs
   always_comb begin
      cmd_ready = 1'b0;
      pipe_en   = 1'b0;
      debugMode = 1'b0;
      ser_load  = 1'b0;
      ser_word  = '0;
      unique case (state_q)
         ST_HALTED: cmd_ready = 1'b1;
         ST_RUN: begin
            cmd_ready = 1'b1;
            pipe_en   = 1'b1;
         end
         ST_STEP: pipe_en = 1'b1;
         ST_DUMP_HDR: begin
            debugMode = 1'b1;
            ser_load  = ser_ready;
            // The counter cannot move during a dump (pipe_en=0), so its
            // value on entry is the value sent.
            ser_word  = hdr_sel_q ? cycle_cnt_q : pc_cap_q;
         end
         ST_DUMP_RD: debugMode = 1'b1;
         ST_DUMP_TX: begin
            debugMode = 1'b1;
            ser_load  = ser_ready && !done_q;
            ser_word  = mem_rdata;
         end
         default: ;
      endcase
   end

   word_serializer u_ser (
      .clk        (clk),
      .rst        (reset),
      .load_i     (ser_load),
      .word_i     (ser_word),
      .ready_o    (ser_ready),
      .tx_valid_o (bus.tx_valid),
      .tx_data_o  (bus.tx_data),
      .tx_ready_i (bus.tx_ready)
   );

endmodule

// File: tb/tb_debug_controller.sv
// tb_debug_controller
//   Stimulus for run/step/halt/dump commands with a behavioural model:
//   expected operating mode per cycle, expected enabled-cycle count and the
//   expected dump byte stream.
module tb_debug_controller;
   import debug_controller_pkg::*;

   localparam int         DW         = 2;
   localparam int         DUMP_BYTES = 8 + 4 * DW;
   localparam logic [7:0] OP_RUN     = 8'h01;
   localparam logic [7:0] OP_STEP    = 8'h02;
   localparam logic [7:0] OP_HALT    = 8'h03;
   localparam logic [7:0] OP_DUMP    = 8'h04;

   typedef enum {M_HALT, M_RUN, M_STEP, M_DUMP} mode_e;

   logic        clk = 1'b0;
   logic        reset;
   logic        pipe_en;
   logic        halt_in;
   logic [31:0] pc_value;
   logic        debugMode;
   logic [31:0] DebugAddress;
   logic [31:0] mem_rdata;
   dbg_state_e  state_o;

   debug_controller_if bus();

   debug_controller #(
      .DUMP_WORDS (DW),
      .CMD_RUN    (OP_RUN),
      .CMD_STEP   (OP_STEP),
      .CMD_HALT   (OP_HALT),
      .CMD_DUMP   (OP_DUMP)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .bus          (bus),
      .pipe_en      (pipe_en),
      .halt_in      (halt_in),
      .pc_value     (pc_value),
      .debugMode    (debugMode),
      .DebugAddress (DebugAddress),
      .mem_rdata    (mem_rdata),
      .state_o      (state_o)
   );

   // ---------------- clock / reset / memory ----------------
   always #5 clk = ~clk;

   logic [31:0] mem_m [DW];
   // DW=2: address bit 0 selects the word.
   always @(posedge clk) mem_rdata <= mem_m[DebugAddress[0]];

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // ---------------- model and scoreboard ----------------
   int          n_checks = 0;
   int          n_fail   = 0;
   mode_e       exp_mode = M_HALT;
   logic [31:0] model_cnt;
   logic [7:0]  exp_q [$];
   logic [7:0]  rx_log [$];
   logic        prev_stall = 1'b0;
   logic [7:0]  prev_data  = 8'h00;

   function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endfunction

   function automatic void push_word(input logic [31:0] w);
      for (int b = 3; b >= 0; b--) exp_q.push_back(w[b*8 +: 8]);
   endfunction

   function automatic logic pick_ready(input int mode, input int c);
      if (mode == 0) return 1'b1;
      if (mode == 1) return c[0];
      return 1'($urandom_range(0, 1));
   endfunction

   // Compare process: every cycle, away from the active edge.
   always @(negedge clk) begin
      logic [7:0] eb;
      check("cmd_ready", {31'd0, bus.cmd_ready}, {31'd0, exp_mode inside {M_HALT, M_RUN}});
      check("pipe_en",   {31'd0, pipe_en},       {31'd0, exp_mode inside {M_RUN, M_STEP}});
      check("debugMode", {31'd0, debugMode},     {31'd0, exp_mode == M_DUMP});
      case (exp_mode)
         M_HALT:  check("state_halted", 32'(state_o), 32'(ST_HALTED));
         M_RUN:   check("state_run",    32'(state_o), 32'(ST_RUN));
         M_STEP:  check("state_step",   32'(state_o), 32'(ST_STEP));
         default: check("state_dump",
                        {31'd0, state_o inside {ST_DUMP_HDR, ST_DUMP_RD, ST_DUMP_TX}}, 32'd1);
      endcase
      if (exp_mode != M_DUMP) begin
         check("tx_valid_idle", {31'd0, bus.tx_valid}, 32'd0);
         check("addr_idle", DebugAddress, 32'd0);
         prev_stall = 1'b0;
      end else begin
         check("addr_range", {31'd0, DebugAddress < DW}, 32'd1);
         if (prev_stall) begin
            check("stall_valid", {31'd0, bus.tx_valid}, 32'd1);
            check("stall_data", {24'd0, bus.tx_data}, {24'd0, prev_data});
         end
         if (bus.tx_valid && bus.tx_ready) begin
            rx_log.push_back(bus.tx_data);
            if (exp_q.size() == 0) begin
               n_checks++;
               n_fail++;
               $display("FAIL extra_byte: got %h expected no byte at %0t", bus.tx_data, $time);
            end else begin
               eb = exp_q.pop_front();
               check("tx_byte", {24'd0, bus.tx_data}, {24'd0, eb});
            end
         end
         prev_stall = bus.tx_valid && !bus.tx_ready;
         prev_data  = bus.tx_data;
      end
   end

   // ---------------- driver tasks ----------------
   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic do_step();
      next_cycle(); bus.cmd_valid = 1'b1; bus.cmd_data = OP_STEP; exp_mode = M_HALT;
      next_cycle(); bus.cmd_valid = 1'b0; exp_mode = M_STEP; model_cnt = model_cnt + 32'd1;
      next_cycle(); exp_mode = M_HALT;
   endtask

   // Command in HALTED that must have no effect.
   task automatic do_noise(input logic [7:0] op);
      next_cycle(); bus.cmd_valid = 1'b1; bus.cmd_data = op; exp_mode = M_HALT;
      halt_in = 1'($urandom_range(0, 1));
      next_cycle(); bus.cmd_valid = 1'b0; halt_in = 1'b0; exp_mode = M_HALT;
   endtask

   // Run for k enabled cycles, stopping via halt_in or CMD_HALT on cycle k.
   task automatic do_run(input int k, input bit by_cmd);
      logic [7:0] op;
      next_cycle(); bus.cmd_valid = 1'b1; bus.cmd_data = OP_RUN; exp_mode = M_HALT;
      for (int i = 1; i <= k; i++) begin
         next_cycle(); exp_mode = M_RUN; bus.cmd_valid = 1'b0; halt_in = 1'b0;
         if (i == k) begin
            if (by_cmd) begin
               bus.cmd_valid = 1'b1; bus.cmd_data = OP_HALT;
            end else begin
               halt_in = 1'b1;
            end
         end else if ($urandom_range(0, 2) == 0) begin
            op = 8'($urandom_range(0, 255));
            if (op == OP_HALT) op = OP_RUN;
            bus.cmd_valid = 1'b1; bus.cmd_data = op;
         end
      end
      model_cnt = model_cnt + 32'(k);
      next_cycle(); bus.cmd_valid = 1'b0; halt_in = 1'b0; exp_mode = M_HALT;
   endtask

   task automatic pulse_reset();
      reset = 1'b1;
      exp_q.delete();
      model_cnt = '0;
      exp_mode  = M_HALT;
      next_cycle();
      reset = 1'b0;
   endtask

   // ready_mode 0: always ready, 1: toggling, 2: random.
   // reset_after > 0: assert reset once that many bytes have been sent.
   task automatic do_dump(input int ready_mode, input int reset_after, input logic [31:0] pc);
      int cycles;
      int budget;
      budget = 20 * DUMP_BYTES + 40;
      next_cycle(); bus.cmd_valid = 1'b1; bus.cmd_data = OP_DUMP; pc_value = pc; exp_mode = M_HALT;
      exp_q.delete();
      rx_log.delete();
      push_word(pc);
      push_word(model_cnt);
      for (int i = 0; i < DW; i++) push_word(mem_m[i]);
      next_cycle(); bus.cmd_valid = 1'b0; exp_mode = M_DUMP; cycles = 1;
      bus.tx_ready = pick_ready(ready_mode, cycles); pc_value = $urandom;
      while (1) begin
         next_cycle();
         if (exp_q.size() == 0) begin
            exp_mode = M_HALT;
            break;
         end
         if (reset_after > 0 && (DUMP_BYTES - exp_q.size()) >= reset_after) begin
            reset = 1'b1;
            #1;
            check("rst_tx_valid", {31'd0, bus.tx_valid}, 32'd0);
            check("rst_tx_data", {24'd0, bus.tx_data}, 32'd0);
            check("rst_state", 32'(state_o), 32'(ST_HALTED));
            check("rst_debugMode", {31'd0, debugMode}, 32'd0);
            check("rst_addr", DebugAddress, 32'd0);
            check("rst_pipe_en", {31'd0, pipe_en}, 32'd0);
            check("rst_cmd_ready", {31'd0, bus.cmd_ready}, 32'd1);
            exp_q.delete();
            model_cnt = '0;
            exp_mode  = M_HALT;
            next_cycle();
            reset = 1'b0;
            return;
         end
         cycles++;
         if (cycles > budget) begin
            n_checks++;
            n_fail++;
            $display("FAIL dump_timeout: got %0d bytes expected %0d", rx_log.size(), DUMP_BYTES);
            pulse_reset();
            return;
         end
         bus.tx_ready = pick_ready(ready_mode, cycles);
         pc_value = $urandom;
      end
      check("dump_len", rx_log.size(), DUMP_BYTES);
      // Unstalled: one load cycle up front plus at most one read cycle per word.
      if (ready_mode == 0) check("dump_no_gaps", {31'd0, cycles <= DUMP_BYTES + DW + 1}, 32'd1);
   endtask

   // ---------------- main sequence ----------------
   logic [7:0] lit45 [16];
   logic [7:0] op;

   initial begin
      reset = 1'b1;
      bus.cmd_valid = 1'b0; bus.cmd_data = 8'h00; bus.tx_ready = 1'b0;
      halt_in = 1'b0; pc_value = '0; model_cnt = '0;
      for (int i = 0; i < DW; i++) mem_m[i] = '0;
      lit45 = '{8'h00, 8'h00, 8'h00, 8'h40, 8'h00, 8'h00, 8'h00, 8'h0D,
                8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h01, 8'h23, 8'h45, 8'h67};
      repeat (3) @(posedge clk);
      #1;
      check("reset_state", 32'(state_o), 32'(ST_HALTED));
      check("reset_pipe_en", {31'd0, pipe_en}, 32'd0);
      check("reset_debugMode", {31'd0, debugMode}, 32'd0);
      check("reset_addr", DebugAddress, 32'd0);
      check("reset_tx_valid", {31'd0, bus.tx_valid}, 32'd0);
      check("reset_tx_data", {24'd0, bus.tx_data}, 32'd0);
      check("reset_cmd_ready", {31'd0, bus.cmd_ready}, 32'd1);
      reset = 1'b0;

      // Three single steps: counter reads 3 in the header.
      repeat (3) do_step();
      do_dump(0, 0, $urandom);
      if (rx_log.size() >= 8) begin
         check("step3_cnt_b0", {24'd0, rx_log[4]}, 32'h00);
         check("step3_cnt_b1", {24'd0, rx_log[5]}, 32'h00);
         check("step3_cnt_b2", {24'd0, rx_log[6]}, 32'h00);
         check("step3_cnt_b3", {24'd0, rx_log[7]}, 32'h03);
      end

      // Ignored opcodes in HALTED.
      do_noise(8'hFF);
      do_noise(OP_HALT);

      // Run stopped by halt_in on the 10th enabled cycle: counter 3+10=13.
      do_run(10, 1'b0);

      // Fixed dump contents.
      mem_m[0] = 32'hDEADBEEF;
      mem_m[1] = 32'h01234567;
      do_dump(0, 0, 32'h0000_0040);
      check("lit_len", rx_log.size(), 32'd16);
      for (int i = 0; i < 16; i++) begin
         if (i < rx_log.size()) check("lit_byte", {24'd0, rx_log[i]}, {24'd0, lit45[i]});
      end

      // Back-pressure.
      do_dump(1, 0, $urandom);
      do_dump(2, 0, $urandom);

      // Reset after the 5th byte, then a full dump from the header.
      do_run(4, 1'b1);
      do_dump(1, 5, $urandom);
      check("abort_bytes", rx_log.size(), 32'd5);
      do_dump(0, 0, 32'h1234_5678);
      check("restart_pc_b0", {24'd0, rx_log[0]}, 32'h12);
      check("restart_pc_b3", {24'd0, rx_log[3]}, 32'h78);
      check("restart_cnt_b3", {24'd0, rx_log[7]}, 32'h00);

      // Random mix.
      for (int n = 0; n < 40; n++) begin
         case ($urandom_range(0, 3))
            0: do_step();
            1: do_run($urandom_range(1, 15), 1'($urandom_range(0, 1)));
            2: begin
               for (int i = 0; i < DW; i++) mem_m[i] = $urandom;
               do_dump($urandom_range(0, 2), 0, $urandom);
            end
            default: begin
               op = 8'($urandom_range(0, 255));
               if (op == OP_RUN || op == OP_STEP || op == OP_DUMP) op = 8'hFF;
               do_noise(op);
            end
         endcase
      end
      do_dump(2, 0, $urandom);

      repeat (2) next_cycle();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
